// File: rtl/fetch_unit_if.sv
// Fetch bus: instruction memory address/data plus the decode valid/ready hold register.
// master = fetch_unit side; slave = memory/decode side.
interface fetch_unit_if;
  logic [31:0] address_out;
  logic [31:0] instruction_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        ready_in;

  modport master (
    output address_out,
    output instr_out,
    output pc_out,
    output valid_out,
    input  instruction_in,
    input  ready_in
  );

  modport slave (
    input  address_out,
    input  instr_out,
    input  pc_out,
    input  valid_out,
    output instruction_in,
    output ready_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC for WAIT_CYCLES edges, captures the memory word, hands it to decode.
// Ports: clk, reset_n, enable_in, redirect_in/redirect_addr_in, bus (fetch_unit_if.master), fault_out/fault_addr_out.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter logic [31:0] TEXT_BASE   = 32'h0040_0000,
  parameter logic [31:0] TEXT_LIMIT  = 32'h0040_007C,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable_in,
  input  logic          redirect_in,
  input  logic [31:0]   redirect_addr_in,
  fetch_unit_if.master  bus,
  output logic          fault_out,
  output logic [31:0]   fault_addr_out
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, FAULT} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   next_addr;
  logic          xfer;
  logic          out_free;
  logic          addr_ok;
  logic          next_ok;
  logic          redir_ok;

  function automatic logic legal(input logic [31:0] a);
    return (a >= TEXT_BASE) && (a <= TEXT_LIMIT) && (a[1:0] == 2'b00);
  endfunction

  // PC+4 wraps naturally; a wrapped value falls outside the segment.
  assign next_addr = bus.address_out + 32'd4;
  assign xfer      = bus.valid_out & bus.ready_in;
  assign out_free  = ~bus.valid_out | bus.ready_in;
  assign addr_ok   = legal(bus.address_out);
  assign next_ok   = legal(next_addr);
  assign redir_ok  = legal(redirect_addr_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.address_out <= RESET_PC;
      bus.instr_out   <= '0;
      bus.pc_out      <= '0;
      bus.valid_out   <= 1'b0;
      fault_out       <= 1'b0;
      fault_addr_out  <= '0;
      count           <= '0;
      state           <= IDLE;
    end else if (redirect_in) begin
      // A transfer on this edge still completes; only later data is flushed.
      bus.address_out <= redirect_addr_in;
      bus.valid_out   <= 1'b0;
      count           <= '0;
      if (redir_ok) begin
        fault_out      <= 1'b0;
        fault_addr_out <= '0;
        state          <= enable_in ? WAIT : IDLE;
      end else begin
        fault_out      <= 1'b1;
        fault_addr_out <= redirect_addr_in;
        state          <= FAULT;
      end
    end else begin
      if (xfer) bus.valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable_in) begin
            if (addr_ok) begin
              state <= WAIT;
              count <= '0;
            end else begin
              state          <= FAULT;
              fault_out      <= 1'b1;
              fault_addr_out <= bus.address_out;
            end
          end
        end
        WAIT: begin
          if (enable_in) begin
            if (count != LAST) begin
              count <= count + CW'(1);
            end else if (out_free) begin
              // Capture overrides the transfer clear above.
              bus.instr_out   <= bus.instruction_in;
              bus.pc_out      <= bus.address_out;
              bus.valid_out   <= 1'b1;
              bus.address_out <= next_addr;
              count           <= '0;
              if (!next_ok) begin
                state          <= FAULT;
                fault_out      <= 1'b1;
                fault_addr_out <= next_addr;
              end
            end
          end
        end
        FAULT: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: delayed memory model plus a transfer scoreboard.
// Scenario tasks run in sequence from one initial block.
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_addr_in = '0;
  logic        fault_out;
  logic [31:0] fault_addr_out;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC    (BASE),
    .TEXT_BASE   (BASE),
    .TEXT_LIMIT  (32'h0040_007C),
    .WAIT_CYCLES (3)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable_in        (enable_in),
    .redirect_in      (redirect_in),
    .redirect_addr_in (redirect_addr_in),
    .bus              (bus),
    .fault_out        (fault_out),
    .fault_addr_out   (fault_addr_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory with a 20-unit read delay.
  always @(bus.address_out)
    bus.instruction_in <= #20 mem_word(bus.address_out);

  // Scoreboard: valid & ready before an edge means that edge transfers.
  always @(negedge clk) begin
    if (reset_n && bus.valid_out && bus.ready_in) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected pc got %h want none", bus.pc_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.pc_out !== e.pc || bus.instr_out !== e.instr) begin
          fails++;
          $display("FAIL sb_xfer pc got %h want %h instr got %h want %h",
                   bus.pc_out, e.pc, bus.instr_out, e.instr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    sb.push_back(e);
  endtask

  task automatic do_reset(input logic en, input logic rdy);
    reset_n          = 1'b0;
    redirect_in      = 1'b0;
    redirect_addr_in = '0;
    enable_in        = en;
    bus.ready_in     = rdy;
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.ready_in = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if (bus.address_out !== BASE) begin
      fails++;
      $display("FAIL rst_addr got %h want %h", bus.address_out, BASE);
    end
    tests++;
    if (bus.valid_out !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid got %b want 0", bus.valid_out);
    end
    tests++;
    if (bus.pc_out !== 32'h0 || bus.instr_out !== 32'h0) begin
      fails++;
      $display("FAIL rst_data got %h/%h want 0/0", bus.pc_out, bus.instr_out);
    end
    tests++;
    if (fault_out !== 1'b0 || fault_addr_out !== 32'h0) begin
      fails++;
      $display("FAIL rst_fault got %b/%h want 0/0", fault_out, fault_addr_out);
    end
  endtask

  task automatic test_stream();
    logic want;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(BASE + 32'(i * 4));
    for (int e = 1; e <= 13; e++) begin
      tick();
      want = (e >= 4) && ((e - 4) % 3 == 0);
      tests++;
      if (bus.valid_out !== want) begin
        fails++;
        $display("FAIL stream_valid edge %0d got %b want %b", e, bus.valid_out, want);
      end
      if (e == 4) begin
        tests++;
        if (bus.pc_out !== BASE) begin
          fails++;
          $display("FAIL stream_pc0 got %h want %h", bus.pc_out, BASE);
        end
      end
    end
    tick();
    bus.ready_in = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL stream_drain got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_stall();
    do_reset(1'b1, 1'b0);
    push(BASE);
    push(BASE + 32'd4);
    repeat (4) tick();
    tests++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== BASE) begin
      fails++;
      $display("FAIL stall_first got %b/%h want 1/%h", bus.valid_out, bus.pc_out, BASE);
    end
    repeat (6) tick();
    tests++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== BASE || bus.instr_out !== mem_word(BASE)) begin
      fails++;
      $display("FAIL stall_hold got %b/%h/%h want 1/%h/%h",
               bus.valid_out, bus.pc_out, bus.instr_out, BASE, mem_word(BASE));
    end
    tests++;
    if (bus.address_out !== BASE + 32'd4) begin
      fails++;
      $display("FAIL stall_addr got %h want %h", bus.address_out, BASE + 32'd4);
    end
    bus.ready_in = 1'b1;
    tick();
    tests++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== BASE + 32'd4 ||
        bus.instr_out !== mem_word(BASE + 32'd4)) begin
      fails++;
      $display("FAIL stall_release got %b/%h/%h want 1/%h/%h", bus.valid_out,
               bus.pc_out, bus.instr_out, BASE + 32'd4, mem_word(BASE + 32'd4));
    end
    tick();
    bus.ready_in = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL stall_drain got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_limit();
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 32; i++) push(BASE + 32'(i * 4));
    repeat (110) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL limit_drain got %0d left want 0", sb.size());
    end
    tests++;
    if (fault_out !== 1'b1 || fault_addr_out !== 32'h0040_0080) begin
      fails++;
      $display("FAIL limit_fault got %b/%h want 1/00400080", fault_out, fault_addr_out);
    end
    tests++;
    if (bus.valid_out !== 1'b0) begin
      fails++;
      $display("FAIL limit_valid got %b want 0", bus.valid_out);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1, 1'b0);
    repeat (5) tick();
    tests++;
    if (bus.valid_out !== 1'b1) begin
      fails++;
      $display("FAIL redir_pre got %b want 1", bus.valid_out);
    end
    redirect_in      = 1'b1;
    redirect_addr_in = BASE + 32'h10;
    tick();
    redirect_in  = 1'b0;
    bus.ready_in = 1'b1;
    push(BASE + 32'h10);
    tests++;
    if (bus.valid_out !== 1'b0 || bus.address_out !== BASE + 32'h10) begin
      fails++;
      $display("FAIL redir_flush got %b/%h want 0/%h",
               bus.valid_out, bus.address_out, BASE + 32'h10);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      tests++;
      if (bus.valid_out !== (e == 3)) begin
        fails++;
        $display("FAIL redir_valid edge %0d got %b want %b", e, bus.valid_out, e == 3);
      end
    end
    tests++;
    if (bus.pc_out !== BASE + 32'h10) begin
      fails++;
      $display("FAIL redir_pc got %h want %h", bus.pc_out, BASE + 32'h10);
    end
    tick();
    bus.ready_in = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL redir_drain got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_misaligned();
    do_reset(1'b1, 1'b0);
    repeat (2) tick();
    redirect_in      = 1'b1;
    redirect_addr_in = BASE + 32'd6;
    tick();
    redirect_in = 1'b0;
    tests++;
    if (fault_out !== 1'b1 || fault_addr_out !== BASE + 32'd6 || bus.valid_out !== 1'b0) begin
      fails++;
      $display("FAIL mis_fault got %b/%h/%b want 1/%h/0",
               fault_out, fault_addr_out, bus.valid_out, BASE + 32'd6);
    end
    repeat (5) tick();
    tests++;
    if (fault_out !== 1'b1 || bus.valid_out !== 1'b0 || bus.address_out !== BASE + 32'd6) begin
      fails++;
      $display("FAIL mis_sticky got %b/%b/%h want 1/0/%h",
               fault_out, bus.valid_out, bus.address_out, BASE + 32'd6);
    end
    redirect_in      = 1'b1;
    redirect_addr_in = BASE;
    tick();
    redirect_in = 1'b0;
    tests++;
    if (fault_out !== 1'b0 || fault_addr_out !== 32'h0 || bus.address_out !== BASE) begin
      fails++;
      $display("FAIL mis_clear got %b/%h/%h want 0/0/%h",
               fault_out, fault_addr_out, bus.address_out, BASE);
    end
    bus.ready_in = 1'b1;
    push(BASE);
    repeat (3) tick();
    tests++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== BASE) begin
      fails++;
      $display("FAIL mis_resume got %b/%h want 1/%h", bus.valid_out, bus.pc_out, BASE);
    end
    tick();
    bus.ready_in = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL mis_drain got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b0);
    repeat (5) tick();
    tests++;
    if (bus.valid_out !== 1'b1 || bus.address_out !== BASE + 32'd4) begin
      fails++;
      $display("FAIL arst_pre got %b/%h want 1/%h",
               bus.valid_out, bus.address_out, BASE + 32'd4);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (bus.valid_out !== 1'b0 || bus.address_out !== BASE ||
        bus.pc_out !== 32'h0 || bus.instr_out !== 32'h0 || fault_out !== 1'b0) begin
      fails++;
      $display("FAIL arst_now got %b/%h/%h/%h/%b want 0/%h/0/0/0", bus.valid_out,
               bus.address_out, bus.pc_out, bus.instr_out, fault_out, BASE);
    end
    tick();
    reset_n      = 1'b1;
    bus.ready_in = 1'b1;
    push(BASE);
    for (int e = 1; e <= 4; e++) begin
      tick();
      tests++;
      if (bus.valid_out !== (e == 4)) begin
        fails++;
        $display("FAIL arst_valid edge %0d got %b want %b", e, bus.valid_out, e == 4);
      end
    end
    tests++;
    if (bus.pc_out !== BASE) begin
      fails++;
      $display("FAIL arst_pc got %h want %h", bus.pc_out, BASE);
    end
    tick();
    bus.ready_in = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL arst_drain got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_limit();
    test_redirect();
    test_misaligned();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the MIPS datapath; drives the instruction memory's address_in and samples its instruction_out.
- Holds the PC and waits a fixed number of cycles for the memory's read delay before capturing each word.
- Presents captured instructions to decode through a valid/ready handshake, overlapping the next fetch with the hold.
- Supports branch/jump redirect and flags out-of-segment or misaligned fetches as a sticky fault.

Parameters:
RESET_PC, 32'h00400000, PC value loaded on reset
TEXT_BASE, 32'h00400000, lowest legal fetch address
TEXT_LIMIT, 32'h0040007C, highest legal fetch address (32-word text segment)
WAIT_CYCLES, 3, clock edges address_out is held stable before instruction_in is sampled (>=1; must cover the 20-unit memory delay)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
enable_in  input  1  fetch enable; low freezes fetch progress
redirect_in  input  1  load new PC (branch/jump), highest priority
redirect_addr_in  input  32  target PC for redirect
address_out  output  32  fetch address to instruction memory address_in
instruction_in  input  32  word from instruction memory instruction_out
instr_out  output  32  captured instruction to decode
pc_out  output  32  address instr_out was fetched from
valid_out  output  1  instr_out/pc_out hold an unconsumed instruction
ready_in  input  1  decode accepts; transfer when valid_out & ready_in at an edge
fault_out  output  1  sticky fetch fault
fault_addr_out  output  32  offending address

Behaviour:
- Reset (async, reset_n=0): address_out=RESET_PC; instr_out=0; pc_out=0; valid_out=0; fault_out=0; fault_addr_out=0; count=0; state=IDLE.
- States: IDLE, WAIT, FAULT.
- Legal address: TEXT_BASE<=addr<=TEXT_LIMIT and addr[1:0]==0. Any other address is illegal.
- IDLE: on an edge with enable_in=1:
  - address_out legal: go to WAIT, count=0.
  - address_out illegal: go to FAULT.
- WAIT, enable_in=1:
  - count<WAIT_CYCLES-1: count increments by 1.
  - count==WAIT_CYCLES-1 and output free (valid_out=0, or ready_in=1 this edge): capture.
    - instr_out<=instruction_in, pc_out<=address_out, valid_out<=1.
    - address_out<=address_out+4, count<=0.
    - If address_out+4 is illegal, go to FAULT; otherwise stay in WAIT.
  - count==WAIT_CYCLES-1 and output not free: hold count, address_out and state (buffer full stall).
- WAIT, enable_in=0: count and address_out frozen; an already-held instruction may still transfer.
- Output register: valid_out clears on a transfer edge unless a capture occurs on the same edge, in which case it stays 1 with the new word. Back-to-back throughput is one instruction per WAIT_CYCLES edges.
- FAULT entry: fault_out<=1, fault_addr_out<=offending address. An instruction already in the output register stays valid and transferable.
- FAULT is left only by redirect or reset. address_out is not advanced in FAULT, and no capture occurs.
- Redirect (any state, priority over everything else): address_out<=redirect_addr_in, count<=0, valid_out<=0, fault_out<=0, fault_addr_out<=0.
  - Next state: FAULT if the target is illegal (fault_out<=1, fault_addr_out<=target), else WAIT if enable_in=1, else IDLE.
  - If valid_out & ready_in on the redirect edge, that transfer still counts; the flush affects only later data.
- Arithmetic: 32-bit, PC+4 wraps modulo 2^32. The wrap is caught by the legality check; no special case is needed.
- Reset mid-WAIT: an in-flight fetch is discarded; fetch restarts from RESET_PC.

Test Plan:
1. Reset, enable_in=1, ready_in=1 -> valid_out first high 4 edges after reset release with pc_out=0x00400000 and instr_out = word 0. Then consecutive pc_out 0x00400004, 0x00400008 every 3 edges.
2. ready_in=0 after first capture -> valid_out stays 1; instr_out/pc_out=0x00400000 held. address_out stalls at 0x00400004 with count=2. Raising ready_in transfers and captures word 1 on the same edge.
3. Sequential run to 0x0040007C -> last valid pc_out=0x0040007C. Then fault_out=1, fault_addr_out=0x00400080, no further valid_out.
4. Redirect to 0x00400010 mid-WAIT with valid_out=1 and ready_in=0 -> valid_out=0 next edge. Next valid has pc_out=0x00400010 three edges later.
5. Redirect to 0x00400006 (misaligned), then redirect to 0x00400000 -> fault_out=1, fault_addr_out=0x00400006; then fault clears and fetch resumes at 0x00400000.
6. reset_n low mid-WAIT (asynchronous, between edges) -> all outputs at reset values immediately. Fetch restarts at 0x00400000 after release.
